dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder (target side) for the core's load/store port.
- Accepts one request at a time over a req/ack handshake and inserts a programmable number of wait states.
- Performs byte, half and word stores with lane masking; returns the aligned 32-bit word on loads.
- Flags misaligned and out-of-range accesses. Replaces the zero-latency data memory so multi-cycle memory behaviour can be exercised.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait states between request capture and ack; 0 is legal.
- INIT_VALUE, 32'h0000_0000: value loaded into every word at reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request valid; held high by the initiator until ack.
- we  input  1  1 = store, 0 = load (same sense as MemRW).
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- size  input  2  00 byte, 01 half, 10 word, 11 reserved (same encoding as MemCtr).
- rdata  output  32  whole aligned word at addr[31:2]; valid only while ack=1.
- ack  output  1  one-cycle completion pulse.
- err  output  1  qualifies ack; 1 = request rejected.
- busy  output  1  high from request capture until the ack cycle, inclusive.

Behaviour:
- Reset is asynchronous, active-high. It forces:
  - state IDLE, ack=0, err=0, busy=0, rdata=0, wait counter=0;
  - every memory word to INIT_VALUE.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - on req=1, capture addr, we, wdata and size, and set busy=1;
  - go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - the counter counts WAIT_CYCLES-1 down to 0, then moves to RESP;
  - input changes during WAIT are ignored (captured values are used).
- RESP: for one cycle, drive ack=1 with err and rdata set as below; next state IDLE, busy=0.
- Latency: req seen in IDLE at edge N gives ack high in cycle N+1+WAIT_CYCLES.
- Back-to-back requests: a req still high in the cycle after ack is treated as a new request. The initiator must drop req in the ack cycle unless it issues a new request.
- Error checks, evaluated on the captured values in RESP:
  - misaligned: size=01 with addr[0]=1, or size=10 with addr[1:0]!=0;
  - size=11;
  - word index addr[31:2] >= DEPTH_WORDS.
  - On any of these: err=1, rdata=0, and no memory write.
- Store with no error, committed on the RESP edge:
  - size 00: write wdata[7:0] into lane addr[1:0];
  - size 01: write wdata[15:0] into half addr[1];
  - size 10: write the full word.
  - Other lanes are preserved. rdata=0 on store acks.
- Load with no error: rdata = stored word at the captured index, sampled after any same-cycle commit. No sign or zero extension here; memsel does that.
- Reset mid-transaction: the transaction is abandoned, no write occurs, no ack is issued, and memory is reinitialised.
- Exactly one outstanding request. req while busy=1 is not queued.

Optional Feature:
- Macro: DMEM_RESPONDER_TOHOST_EN.
- When defined:
  - adds ports tohost (output 32) and tohost_valid (output 1), both reset to 0;
  - a word store to byte address 32'hFFFF_FFF0 is acked with err=0, is not range-checked, and does not write memory;
  - the store latches wdata into tohost and sets tohost_valid=1, which stays sticky until reset;
  - a load from 32'hFFFF_FFF0 returns tohost.
- When not defined: no extra ports; 32'hFFFF_FFF0 is out of range and is acked with err=1.

Test Plan:
- Reset then load: rst pulse, load word at addr 0x0 with WAIT_CYCLES=2 -> ack exactly 3 cycles after req capture, err=0, rdata=INIT_VALUE, busy high for 3 cycles.
- Lane merge: store word 0x11223344 to 0x10, store byte 0xAA to 0x12, store half 0xBEEF to 0x10, load word 0x10 -> rdata=0x11AABEEF.
- Misaligned store: store half 0x5555 to 0x21, then load word 0x20 -> first ack has err=1; load returns the previous contents unchanged.
- Range check: load from 4*DEPTH_WORDS (0x1000) -> err=1, rdata=0. Load from 0xFFC -> err=0.
- Reset mid-operation: issue store 0xDEADBEEF to 0x40, assert rst during WAIT -> no ack; after reset, load 0x40 returns INIT_VALUE. Repeat with WAIT_CYCLES=0 and back-to-back req held high -> acks on consecutive even cycles.
- With DMEM_RESPONDER_TOHOST_EN: store word 0x00000001 to 0xFFFFFFF0 -> ack with err=0, tohost=1, tohost_valid=1. Without the macro, the same store gives err=1.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: target-side data memory for the core load/store port.
// One request at a time over req/ack, WAIT_CYCLES wait states, byte/half/word
// stores with lane masking, aligned word returned on loads, err on misaligned,
// reserved-size or out-of-range accesses.
// Optional build macro DMEM_RESPONDER_TOHOST_EN adds a tohost mailbox at
// byte address 32'hFFFF_FFF0 with ports tohost/tohost_valid.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
`ifdef DMEM_RESPONDER_TOHOST_EN
    ,
    output logic [31:0] tohost,
    output logic        tohost_valid
`endif
);

    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned WLOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [CW-1:0] cnt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [1:0]  size_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [31:0]   word_rd;
    logic [31:0]   word_wr;
    logic          misaligned;
    logic          bad_size;
    logic          out_of_range;
    logic          req_err;
    logic          commit;
    logic          tohost_hit;

    assign idx     = addr_q[AW+1:2];
    assign word_rd = mem[idx];

`ifdef DMEM_RESPONDER_TOHOST_EN
    localparam logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0;
    // Mailbox hit: word stores, or loads of any legal size, at the tohost address.
    assign tohost_hit = (addr_q == TOHOST_ADDR) &&
                        (we_q ? (size_q == 2'b10) : (size_q != 2'b11));
`else
    assign tohost_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Wait-state counter: loaded with WAIT_CYCLES-1 on capture, counts down in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_IDLE && req) begin
            cnt <= CW'(WLOAD);
        end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Request capture; inputs are ignored outside IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
        end else if (state == S_IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= we;
            size_q  <= size;
        end
    end

    // Error classification on the captured request.
    always_comb begin
        misaligned   = ((size_q == 2'b01) && addr_q[0]) ||
                       ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
        bad_size     = (size_q == 2'b11);
        out_of_range = ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
        req_err      = !tohost_hit && (misaligned || bad_size || out_of_range);
        commit       = (state == S_RESP) && we_q && !req_err && !tohost_hit;
    end

    // Lane merge of store data into the current word.
    always_comb begin
        word_wr = word_rd;
        case (size_q)
            2'b00: word_wr[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) begin
                    word_wr[31:16] = wdata_q[15:0];
                end else begin
                    word_wr[15:0] = wdata_q[15:0];
                end
            end
            2'b10:   word_wr = wdata_q;
            default: word_wr = word_rd;
        endcase
    end

    // Storage array: reinitialised on reset, written on the RESP edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[AW'(i)] <= INIT_VALUE;
            end
        end else if (commit) begin
            mem[idx] <= word_wr;
        end
    end

`ifdef DMEM_RESPONDER_TOHOST_EN
    // Tohost mailbox: latches store data, valid is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tohost       <= '0;
            tohost_valid <= 1'b0;
        end else if (state == S_RESP && we_q && tohost_hit) begin
            tohost       <= wdata_q;
            tohost_valid <= 1'b1;
        end
    end
`endif

    // Outputs decoded from state; rdata only carries data on an error-free load ack.
    always_comb begin
        ack   = (state == S_RESP);
        busy  = (state != S_IDLE);
        err   = (state == S_RESP) && req_err;
        rdata = '0;
        if (state == S_RESP && !req_err && !we_q) begin
`ifdef DMEM_RESPONDER_TOHOST_EN
            rdata = tohost_hit ? tohost : word_rd;
`else
            rdata = word_rd;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus random traffic,
// checked every cycle against a byte-addressed behavioural model.
module tb_dmem_responder;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned WAITC  = 2;
    localparam logic [31:0] INIT   = 32'hCAFE_0123;
    localparam int unsigned DEPTH0 = 16;
    localparam logic [31:0] INIT0  = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  size = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    logic        req0 = 1'b0;
    logic        we0 = 1'b0;
    logic [31:0] addr0 = 32'h4;
    logic [31:0] wdata0 = '0;
    logic [1:0]  size0 = 2'b10;
    logic [31:0] rdata0;
    logic        ack0;
    logic        err0;
    logic        busy0;

`ifdef DMEM_RESPONDER_TOHOST_EN
    logic [31:0] tohost;
    logic        tohost_valid;
    logic [31:0] tohost0;
    logic        tohost_valid0;
`endif

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC),
        .INIT_VALUE(INIT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .size(size), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
`ifdef DMEM_RESPONDER_TOHOST_EN
        , .tohost(tohost), .tohost_valid(tohost_valid)
`endif
    );

    dmem_responder #(
        .DEPTH_WORDS(DEPTH0),
        .WAIT_CYCLES(0),
        .INIT_VALUE(INIT0)
    ) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .size(size0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
`ifdef DMEM_RESPONDER_TOHOST_EN
        , .tohost(tohost0), .tohost_valid(tohost_valid0)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Behavioural model: byte-addressed memory plus the one outstanding transaction.
    logic [7:0]  mb [4*DEPTH];
    bit          txn_active = 0;
    int          txn_start = 0;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_size;
    logic [31:0] m_th = '0;
    bit          m_thv = 0;
    logic [31:0] m_th_d = '0;
    bit          m_thv_d = 0;
    int          b2b_start = 32'h3FFF_0000;

    // Observations of the DUT used by the literal checks.
    int          obs_ack_cyc = 0;
    logic        obs_err = 0;
    logic [31:0] obs_rdata = '0;
    int          busy_cnt = 0;
    int          ack0_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        logic [31:0] t;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            t = INIT >> (8 * (i % 4));
            mb[i] = t[7:0];
        end
        m_th = '0; m_thv = 0; m_th_d = '0; m_thv_d = 0;
    endtask

    task automatic model_do(output bit e, output logic [31:0] rd);
        longint unsigned a;
        longint unsigned nb;
        logic [31:0] t;
        a  = m_addr;
        nb = 1 << m_size;
        e  = (m_size == 2'd3) || ((a % nb) != 0) || ((a / 4) >= DEPTH);
        rd = '0;
`ifdef DMEM_RESPONDER_TOHOST_EN
        if (m_addr == 32'hFFFF_FFF0 && (m_we ? (m_size == 2'd2) : (m_size != 2'd3))) begin
            e = 0;
            if (m_we) begin
                m_th = m_wdata; m_thv = 1;
            end else begin
                rd = m_th;
            end
            return;
        end
`endif
        if (!e) begin
            if (m_we) begin
                for (longint unsigned k = 0; k < nb; k++) begin
                    t = m_wdata >> (8 * k);
                    mb[int'(a + k)] = t[7:0];
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    rd = rd | (32'(mb[int'(a - (a % 4)) + k]) << (8 * k));
                end
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Single compare process: every cycle, DUT outputs against the model.
    bit          ea, eb, ee, ea0;
    logic [31:0] er;
    always @(negedge clk) begin
        ea = txn_active && (cyc == txn_start + WAITC);
        eb = txn_active && (cyc >= txn_start) && (cyc <= txn_start + WAITC);
        ee = 0;
        er = '0;
        if (ea) begin
            model_do(ee, er);
            txn_active = 0;
        end
        if (ack) begin
            obs_ack_cyc = cyc; obs_err = err; obs_rdata = rdata;
        end
        if (busy) busy_cnt++;
        chk("ack", ack, ea);
        chk("busy", busy, eb);
        if (ea || rst) begin
            chk("err", err, ee);
            chk("rdata", rdata, er);
        end
`ifdef DMEM_RESPONDER_TOHOST_EN
        chk("tohost", tohost, m_th_d);
        chk("tohost_valid", tohost_valid, m_thv_d);
        m_th_d = m_th; m_thv_d = m_thv;
`endif
        ea0 = (cyc >= b2b_start) && (cyc <= b2b_start + 8) && (((cyc - b2b_start) % 2) == 0);
        if (ack0) ack0_cnt++;
        chk("ack0", ack0, ea0);
        chk("busy0", busy0, ea0);
        if (ea0 || rst) begin
            chk("err0", err0, 1'b0);
            chk("rdata0", rdata0, ea0 ? INIT0 : 32'h0);
        end
    end

    // One transaction: req held until the ack cycle, other inputs scrambled while waiting.
    task automatic do_txn(input bit we_i, input logic [31:0] a_i, input logic [31:0] d_i,
                          input logic [1:0] s_i);
        @(posedge clk); #2;
        req = 1; we = we_i; addr = a_i; wdata = d_i; size = s_i;
        @(posedge clk); #2;
        m_we = we_i; m_addr = a_i; m_wdata = d_i; m_size = s_i;
        txn_start = cyc; txn_active = 1;
        while (cyc < txn_start + WAITC) begin
            @(posedge clk); #2;
            we = 1'($urandom); addr = $urandom; wdata = $urandom; size = 2'($urandom);
        end
        req = 0;
        for (int i = 0; i < 10 && txn_active; i++) begin
            @(posedge clk); #2;
        end
    endtask

    // Store captured, then reset asserted during WAIT.
    task automatic do_abort(input logic [31:0] a_i, input logic [31:0] d_i);
        @(posedge clk); #2;
        req = 1; we = 1; addr = a_i; wdata = d_i; size = 2'b10;
        @(posedge clk); #2;
        txn_start = cyc; txn_active = 1;
        @(posedge clk); #2;
        rst = 1; req = 0; txn_active = 0;
        model_reset();
        @(posedge clk); #2;
        rst = 0;
    endtask

    int unsigned r;
    logic [31:0] ra;
    logic [1:0]  rs;

    initial begin
        model_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #2 rst = 0;

        // Reset then load: latency, busy width, init contents.
        busy_cnt = 0;
        do_txn(0, 32'h0, 32'h0, 2'b10);
        chk("load0_latency", 32'(obs_ack_cyc - txn_start), 32'd2);
        chk("load0_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("load0_err", obs_err, 1'b0);
        chk("load0_rdata", obs_rdata, 32'hCAFE_0123);

        // Lane merge.
        do_txn(1, 32'h10, 32'h1122_3344, 2'b10);
        do_txn(1, 32'h12, 32'h0000_00AA, 2'b00);
        do_txn(1, 32'h10, 32'h0000_BEEF, 2'b01);
        do_txn(0, 32'h10, 32'h0, 2'b10);
        chk("merge_rdata", obs_rdata, 32'h11AA_BEEF);
        chk("merge_model", {mb[16'h13], mb[16'h12], mb[16'h11], mb[16'h10]}, 32'h11AA_BEEF);

        // Misaligned store is rejected and leaves memory untouched.
        do_txn(1, 32'h21, 32'h0000_5555, 2'b01);
        chk("misalign_err", obs_err, 1'b1);
        do_txn(0, 32'h20, 32'h0, 2'b10);
        chk("misalign_keep", obs_rdata, 32'hCAFE_0123);

        // Range boundary.
        do_txn(0, 32'h1000, 32'h0, 2'b10);
        chk("range_hi_err", obs_err, 1'b1);
        chk("range_hi_rdata", obs_rdata, 32'h0);
        do_txn(0, 32'hFFC, 32'h0, 2'b10);
        chk("range_top_err", obs_err, 1'b0);

        // Reset mid-transaction reinitialises memory.
        do_txn(1, 32'h44, 32'h1234_5678, 2'b10);
        do_abort(32'h40, 32'hDEAD_BEEF);
        do_txn(0, 32'h40, 32'h0, 2'b10);
        chk("abort_0x40", obs_rdata, 32'hCAFE_0123);
        do_txn(0, 32'h44, 32'h0, 2'b10);
        chk("abort_0x44", obs_rdata, 32'hCAFE_0123);

        // Tohost address.
        do_txn(1, 32'hFFFF_FFF0, 32'h0000_0001, 2'b10);
`ifdef DMEM_RESPONDER_TOHOST_EN
        chk("tohost_err", obs_err, 1'b0);
        chk("tohost_val", tohost, 32'h1);
        chk("tohost_vld", tohost_valid, 1'b1);
`else
        chk("tohost_err", obs_err, 1'b1);
`endif

        // Zero-wait instance with req held high: acks on alternate cycles.
        @(posedge clk); #2;
        ack0_cnt = 0;
        req0 = 1;
        b2b_start = cyc + 1;
        while (cyc < b2b_start + 8) begin
            @(posedge clk); #2;
        end
        req0 = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("b2b_ack_count", 32'(ack0_cnt), 32'd5);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 11);
            if (r == 0)      ra = $urandom;
            else if (r == 1) ra = 32'hFFFF_FFF0;
            else if (r == 2) ra = 32'hFFC + $urandom_range(0, 7);
            else             ra = $urandom_range(0, 63);
            rs = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_txn(1'($urandom_range(0, 1)), ra, $urandom, rs);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
